// File: rtl/decomp_line_ctrl_if.sv
// decomp_line_ctrl_if: request, compressed-store, decompressor and response signals of the line controller.
interface decomp_line_ctrl_if;
  logic         req0_valid, req1_valid;
  logic [3:0]   req0_addr, req1_addr;
  logic         req0_ready, req1_ready;
  logic         mem_en;
  logic [3:0]   mem_addr;
  logic [259:0] mem_rdata;
  logic [259:0] dec_data;
  logic         dec_start;
  logic [255:0] dec_line;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [255:0] rsp_line;
  logic         rsp_err;
  logic         busy;
  modport master (
    output req0_valid, req1_valid, req0_addr, req1_addr, mem_rdata, dec_line, rsp_ready,
    input  req0_ready, req1_ready, mem_en, mem_addr, dec_data, dec_start,
           rsp_valid, rsp_id, rsp_line, rsp_err, busy
  );
  modport slave (
    input  req0_valid, req1_valid, req0_addr, req1_addr, mem_rdata, dec_line, rsp_ready,
    output req0_ready, req1_ready, mem_en, mem_addr, dec_data, dec_start,
           rsp_valid, rsp_id, rsp_line, rsp_err, busy
  );
endinterface

// File: rtl/decomp_line_ctrl.sv
// decomp_line_ctrl: two-requester round-robin line reader that fetches an encoded line and runs it through the decompressor.
module decomp_line_ctrl #(
  parameter int MEM_LAT     = 1,
  parameter int DEC_LAT     = 1,
  parameter int ADDR_OFFSET = 6
) (
  input  logic clk,
  input  logic rst,
  decomp_line_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, WMEM, DEC, WDEC, RESP} state_t;
  state_t       state_q, state_d;
  logic         id_q, id_d, ptr_q, ptr_d, err_q, err_d;
  logic         mem_en_q, mem_en_d, dec_start_q, dec_start_d, rsp_valid_q, rsp_valid_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [3:0]   mem_addr_q, mem_addr_d;
  logic [259:0] word_q, word_d;
  logic [255:0] line_q, line_d;
  logic         gnt0, gnt1, rdata_ok, word_ok;
  always_comb begin
    gnt0 = bus.req0_valid && (!bus.req1_valid || !ptr_q) && state_q == IDLE && !rst;
    gnt1 = bus.req1_valid && (!bus.req0_valid ||  ptr_q) && state_q == IDLE && !rst;
    rdata_ok = !bus.mem_rdata[3] || &bus.mem_rdata[3:0];
    word_ok  = !word_q[3] || &word_q[3:0];
    state_d     = state_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    line_d      = line_q;
    rsp_valid_d = rsp_valid_q;
    mem_en_d    = 1'b0;
    dec_start_d = 1'b0;
    mem_addr_d  = '0;
    case (state_q)
      IDLE: if (gnt0 || gnt1) begin
        id_d       = gnt1;
        ptr_d      = gnt0;
        mem_en_d   = 1'b1;
        mem_addr_d = (gnt1 ? bus.req1_addr : bus.req0_addr) + 4'(ADDR_OFFSET);
        state_d    = RD;
      end
      RD: begin
        cnt_d   = '0;
        state_d = WMEM;
      end
      WMEM: if (cnt_q == 2'(MEM_LAT - 1)) begin
        word_d      = bus.mem_rdata;
        dec_start_d = rdata_ok;
        state_d     = DEC;
      end else cnt_d = cnt_q + 2'd1;
      DEC: begin
        cnt_d   = '0;
        state_d = WDEC;
      end
      WDEC: if (cnt_q == 2'(DEC_LAT - 1)) begin
        line_d      = word_ok ? bus.dec_line : '0;
        err_d       = !word_ok;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end else cnt_d = cnt_q + 2'd1;
      RESP: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      ptr_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      word_q      <= '0;
      line_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      dec_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      line_q      <= line_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      dec_start_q <= dec_start_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.dec_start  = dec_start_q;
  assign bus.dec_data   = (state_q == DEC || state_q == WDEC) ? word_q : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_valid_q & id_q;
  assign bus.rsp_err    = rsp_valid_q & err_q;
  assign bus.rsp_line   = rsp_valid_q ? line_q : '0;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_decomp_line_ctrl.sv
// tb_decomp_line_ctrl: directed checks of arbitration, latency, wrap, error encoding, backpressure and reset.
module tb_decomp_line_ctrl;
  localparam int ML = 1;
  localparam int DL = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  int checks = 0;
  int failures = 0;
  int ovl = 0;
  always #5 clk = ~clk;
  decomp_line_ctrl_if bus_a();
  decomp_line_ctrl_if bus_b();
  decomp_line_ctrl dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  decomp_line_ctrl #(.MEM_LAT(2), .DEC_LAT(3), .ADDR_OFFSET(6)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));
  logic [259:0] mem_word;
  logic [3:0]   mpipe, dpipe;
  logic [259:0] dec_in;
  always @(posedge clk) begin
    if (rst) begin
      mpipe <= '0;
      dpipe <= '0;
    end else begin
      mpipe <= {mpipe[2:0], bus_a.mem_en};
      dpipe <= {dpipe[2:0], bus_a.dec_start};
      if (bus_a.dec_start) dec_in <= bus_a.dec_data;
    end
  end
  assign bus_a.mem_rdata = mpipe[ML-1] ? mem_word : {65{4'hA}};
  assign bus_a.dec_line  = dpipe[DL-1] ? ((dec_in[3:0] == 4'd0) ? 256'h0 : {4{dec_in[67:4]}}) : {8{32'hDEADBEEF}};
  assign bus_b.mem_rdata = {192'h0, 64'hCAFEF00D12345678, 4'h1};
  assign bus_b.dec_line  = {4{64'h0123456789ABCDEF}};
  always @(negedge clk) if ($countones({bus_a.mem_en, bus_a.dec_start, bus_a.rsp_valid}) > 1) ovl++;
  logic         o_acc, o_gid, o_both, o_rid, o_rerr, o_chg, o_rdy;
  logic [3:0]   o_maddr;
  logic [255:0] o_rline;
  int           o_mcyc, o_nmem, o_rcyc, o_nstart, o_nrsp, o_nhs;
  task automatic do_txn(input logic v0, input logic v1, input logic [3:0] a0, input logic [3:0] a1, input int hold);
    o_mcyc = -1; o_nmem = 0; o_rcyc = -1; o_nstart = 0; o_nrsp = 0; o_nhs = 0;
    o_chg = 1'b0; o_rdy = 1'b0; o_maddr = 'x; o_rid = 'x; o_rerr = 'x; o_rline = 'x;
    bus_a.rsp_ready = 1'b0;
    bus_a.req0_valid = v0; bus_a.req1_valid = v1;
    bus_a.req0_addr = a0;  bus_a.req1_addr = a1;
    #1;
    o_acc  = bus_a.req0_ready | bus_a.req1_ready;
    o_both = bus_a.req0_ready & bus_a.req1_ready;
    o_gid  = bus_a.req1_ready;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (o_gid) bus_a.req1_valid = 1'b0;
        else bus_a.req0_valid = 1'b0;
      end
      if (bus_a.busy && (bus_a.req0_ready || bus_a.req1_ready)) o_rdy = 1'b1;
      if (bus_a.mem_en) begin
        o_mcyc = n; o_nmem++; o_maddr = bus_a.mem_addr;
      end
      if (bus_a.dec_start) o_nstart++;
      if (bus_a.rsp_valid) begin
        if (o_nrsp == 0) begin
          o_rcyc = n; o_rid = bus_a.rsp_id; o_rerr = bus_a.rsp_err; o_rline = bus_a.rsp_line;
        end else if ({o_rid, o_rerr, o_rline} !== {bus_a.rsp_id, bus_a.rsp_err, bus_a.rsp_line}) o_chg = 1'b1;
        o_nrsp++;
        bus_a.rsp_ready = o_nrsp > hold;
        if (bus_a.rsp_ready) o_nhs++;
      end else if (o_nrsp > 0) break;
    end
  endtask
  task automatic test_reset;
    bus_a.req0_valid = 1'b1; bus_a.req1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus_a.req0_ready, bus_a.req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {bus_a.req0_ready, bus_a.req1_ready}); end
    checks++;
    if ({bus_a.mem_en, bus_a.mem_addr, bus_a.dec_start, bus_a.rsp_valid, bus_a.busy} !== 8'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", {bus_a.mem_en, bus_a.mem_addr, bus_a.dec_start, bus_a.rsp_valid, bus_a.busy}); end
    checks++;
    if (bus_a.dec_data !== 260'h0) begin failures++; $display("FAIL reset_dec_data got=%h exp=0", bus_a.dec_data); end
    checks++;
    if ({bus_a.rsp_id, bus_a.rsp_err, bus_a.rsp_line} !== 258'h0) begin failures++; $display("FAIL reset_rsp got=%h exp=0", {bus_a.rsp_id, bus_a.rsp_err, bus_a.rsp_line}); end
    bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0;
    rst = 1'b0; rst_b = 1'b0;
  endtask
  task automatic test_basic;
    mem_word = {192'h0, 64'h1122334455667788, 4'h1};
    do_txn(1'b1, 1'b0, 4'd2, 4'd0, 0);
    checks++; if (o_acc !== 1'b1 || o_gid !== 1'b0) begin failures++; $display("FAIL basic_grant got=%b%b exp=10", o_acc, o_gid); end
    checks++; if (o_maddr !== 4'd8) begin failures++; $display("FAIL basic_mem_addr got=%0d exp=8", o_maddr); end
    checks++; if (o_mcyc != 1 || o_nmem != 1) begin failures++; $display("FAIL basic_mem_en got cyc=%0d n=%0d exp cyc=1 n=1", o_mcyc, o_nmem); end
    checks++; if (o_nstart != 1) begin failures++; $display("FAIL basic_dec_start got=%0d exp=1", o_nstart); end
    checks++; if (o_rcyc != 5) begin failures++; $display("FAIL basic_rsp_cycle got=%0d exp=5", o_rcyc); end
    checks++; if (o_rline !== {4{64'h1122334455667788}}) begin failures++; $display("FAIL basic_rsp_line got=%h exp=%h", o_rline, {4{64'h1122334455667788}}); end
    checks++; if ({o_rid, o_rerr} !== 2'b00) begin failures++; $display("FAIL basic_id_err got=%b exp=00", {o_rid, o_rerr}); end
    checks++; if (o_nhs != 1) begin failures++; $display("FAIL basic_handshakes got=%0d exp=1", o_nhs); end
  endtask
  task automatic test_arb;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_word = {192'h0, 64'h00000000000000AB, 4'h1};
    for (int r = 0; r < 2; r++) begin
      do_txn(1'b1, 1'b1, 4'd3, 4'd5, 0);
      checks++; if (o_both !== 1'b0 || o_gid !== 1'b0) begin failures++; $display("FAIL arb_first_%0d got both=%b gid=%b exp both=0 gid=0", r, o_both, o_gid); end
      checks++; if (o_maddr !== 4'd9 || o_rid !== 1'b0) begin failures++; $display("FAIL arb_req0_%0d got addr=%0d id=%b exp addr=9 id=0", r, o_maddr, o_rid); end
      do_txn(1'b0, 1'b1, 4'd3, 4'd5, 0);
      checks++; if (o_acc !== 1'b1 || o_gid !== 1'b1) begin failures++; $display("FAIL arb_second_%0d got acc=%b gid=%b exp acc=1 gid=1", r, o_acc, o_gid); end
      checks++; if (o_maddr !== 4'd11 || o_rid !== 1'b1) begin failures++; $display("FAIL arb_req1_%0d got addr=%0d id=%b exp addr=11 id=1", r, o_maddr, o_rid); end
    end
  endtask
  task automatic test_wrap;
    mem_word = {192'h0, 64'hFFFFFFFFFFFFFFFF, 4'h0};
    do_txn(1'b0, 1'b1, 4'd0, 4'd12, 0);
    checks++; if (o_maddr !== 4'd2) begin failures++; $display("FAIL wrap_mem_addr got=%0d exp=2", o_maddr); end
    checks++; if (o_rline !== 256'h0 || o_rerr !== 1'b0 || o_rid !== 1'b1) begin failures++; $display("FAIL wrap_rsp got line=%h err=%b id=%b exp line=0 err=0 id=1", o_rline, o_rerr, o_rid); end
  endtask
  task automatic test_err;
    mem_word = {192'h0, 64'h1234567812345678, 4'h9};
    do_txn(1'b1, 1'b0, 4'd4, 4'd0, 0);
    checks++; if (o_nstart != 0) begin failures++; $display("FAIL err_dec_start got=%0d exp=0", o_nstart); end
    checks++; if (o_rerr !== 1'b1) begin failures++; $display("FAIL err_flag got=%b exp=1", o_rerr); end
    checks++; if (o_rline !== 256'h0) begin failures++; $display("FAIL err_line got=%h exp=0", o_rline); end
    checks++; if (o_rcyc != 5) begin failures++; $display("FAIL err_rsp_cycle got=%0d exp=5", o_rcyc); end
  endtask
  task automatic test_backpressure;
    mem_word = {192'h0, 64'h0F0E0D0C0B0A0908, 4'h2};
    do_txn(1'b0, 1'b1, 4'd0, 4'd7, 3);
    checks++; if (o_nrsp != 4) begin failures++; $display("FAIL bp_rsp_cycles got=%0d exp=4", o_nrsp); end
    checks++; if (o_chg !== 1'b0) begin failures++; $display("FAIL bp_stable got=%b exp=0", o_chg); end
    checks++; if (o_rdy !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", o_rdy); end
    checks++; if (o_nhs != 1) begin failures++; $display("FAIL bp_handshakes got=%0d exp=1", o_nhs); end
    checks++; if (o_rline !== {4{64'h0F0E0D0C0B0A0908}} || o_rid !== 1'b1) begin failures++; $display("FAIL bp_rsp got line=%h id=%b exp line=%h id=1", o_rline, o_rid, {4{64'h0F0E0D0C0B0A0908}}); end
  endtask
  task automatic test_reset_mid;
    logic seen, busy_seen, rdy;
    int rc;
    seen = 1'b0; busy_seen = 1'b0; rc = -1;
    bus_b.rsp_ready = 1'b1;
    bus_b.req0_valid = 1'b1; bus_b.req0_addr = 4'd1;
    #1;
    rdy = bus_b.req0_ready;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      bus_b.req0_valid = 1'b0;
    end
    checks++; if (rdy !== 1'b1 || bus_b.busy !== 1'b1) begin failures++; $display("FAIL rmid_in_flight got rdy=%b busy=%b exp 1 1", rdy, bus_b.busy); end
    bus_b.req1_valid = 1'b1;
    rst_b = 1'b1;
    #1;
    checks++;
    if ({bus_b.req0_ready, bus_b.req1_ready, bus_b.mem_en, bus_b.mem_addr, bus_b.dec_data, bus_b.dec_start,
         bus_b.rsp_valid, bus_b.rsp_id, bus_b.rsp_line, bus_b.rsp_err, bus_b.busy} !== 529'h0) begin
      failures++; $display("FAIL rmid_outputs_zero got busy=%b dec_start=%b dec_data=%h", bus_b.busy, bus_b.dec_start, bus_b.dec_data);
    end
    @(negedge clk);
    bus_b.req1_valid = 1'b0;
    rst_b = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus_b.rsp_valid) seen = 1'b1;
      if (bus_b.busy) busy_seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || busy_seen !== 1'b0) begin failures++; $display("FAIL rmid_dropped got rsp=%b busy=%b exp 0 0", seen, busy_seen); end
    bus_b.req0_valid = 1'b1; bus_b.req0_addr = 4'd1;
    #1;
    rdy = bus_b.req0_ready;
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL rmid_accept got=%b exp=1", rdy); end
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      bus_b.req0_valid = 1'b0;
      if (bus_b.rsp_valid && rc < 0) begin
        rc = n;
        checks++; if (bus_b.rsp_line !== {4{64'h0123456789ABCDEF}} || bus_b.rsp_err !== 1'b0) begin failures++; $display("FAIL rmid_rsp_line got=%h exp=%h", bus_b.rsp_line, {4{64'h0123456789ABCDEF}}); end
      end
    end
    checks++; if (rc != 8) begin failures++; $display("FAIL rmid_rsp_cycle got=%0d exp=8", rc); end
  endtask
  task automatic test_exclusive;
    checks++; if (ovl != 0) begin failures++; $display("FAIL exclusive_strobes got=%0d exp=0", ovl); end
  endtask
  initial begin
    bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0; bus_a.req0_addr = '0; bus_a.req1_addr = '0; bus_a.rsp_ready = 1'b0;
    bus_b.req0_valid = 1'b0; bus_b.req1_valid = 1'b0; bus_b.req0_addr = '0; bus_b.req1_addr = '0; bus_b.rsp_ready = 1'b0;
    mem_word = '0;
    test_reset;
    test_basic;
    test_arb;
    test_wrap;
    test_err;
    test_backpressure;
    test_reset_mid;
    test_exclusive;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
